// File: rtl/jellyvl_etherneco_synctimer_node.sv
// Etherneco sync-timer slave node: parses the master command packet, sets or
// nudges the local timer, and writes its round-trip time into the return packet.
// Ports: clk/reset (sync, active-high); node_id; current_time in;
//   set_time/set_valid and adjust_sign/adjust_valid/adjust_ready timer control;
//   cmd_rx_* / cmd_payload_* command packet stream;
//   ret_rx_* / ret_payload_* return packet stream; ret_replace_* substitute byte.
// Optional feature: define ETHERNECO_SYNCTIMER_NODE_DEADBAND_EN to skip
//   adjust when |diff| <= DEADBAND.
module jellyvl_etherneco_synctimer_node #(
  parameter int TIMER_WIDTH = 64,
  parameter int MAX_NODES   = 2,
  parameter int DEADBAND    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             node_id,
  input  logic [TIMER_WIDTH-1:0] current_time,
  output logic [TIMER_WIDTH-1:0] set_time,
  output logic                   set_valid,
  output logic                   adjust_sign,
  output logic                   adjust_valid,
  input  logic                   adjust_ready,
  input  logic                   cmd_rx_start,
  input  logic                   cmd_rx_end,
  input  logic                   cmd_rx_error,
  input  logic [15:0]            cmd_rx_length,
  input  logic [15:0]            cmd_payload_pos,
  input  logic [7:0]             cmd_payload_data,
  input  logic                   cmd_payload_valid,
  input  logic                   ret_rx_start,
  input  logic                   ret_rx_end,
  input  logic                   ret_rx_error,
  input  logic [15:0]            ret_payload_pos,
  input  logic                   ret_payload_valid,
  output logic [7:0]             ret_replace_data,
  output logic                   ret_replace_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SET  = 2'd2;
  localparam logic [1:0] S_ADJ  = 2'd3;

  localparam logic [15:0] EXP_LEN = 16'(8 + 4 * MAX_NODES);
  localparam logic [TIMER_WIDTH-1:0] DB_LIM = TIMER_WIDTH'(DEADBAND);
`ifdef ETHERNECO_SYNCTIMER_NODE_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic [1:0]             state_q, state_d;
  logic [TIMER_WIDTH-1:0] local_start_q, local_start_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [63:0]            rx_time_q, rx_time_d;
  logic [31:0]            own_offset_q, own_offset_d;
  logic                   cmd_seen_q, cmd_seen_d;
  logic                   meas_valid_q, meas_valid_d;
  logic [31:0]            rtt_q, rtt_d;
  logic [TIMER_WIDTH-1:0] set_time_q, set_time_d;
  logic                   set_valid_q, set_valid_d;
  logic                   adjust_sign_q, adjust_sign_d;
  logic                   adjust_valid_q, adjust_valid_d;

  logic                   node_ok;
  logic [15:0]            slot_base;
  logic [15:0]            slot_end;
  logic                   cmd_in_slot;
  logic [1:0]             cmd_lane;
  logic [2:0]             time_lane;
  logic                   ret_hit;
  logic [1:0]             ret_lane;
  logic                   pkt_ok;
  logic [TIMER_WIDTH-1:0] target;
  logic [TIMER_WIDTH-1:0] diff;
  logic [TIMER_WIDTH-1:0] diff_mag;
  logic [TIMER_WIDTH-1:0] elapsed;
  logic                   adj_need;

  assign node_ok   = 32'(node_id) < MAX_NODES;
  assign slot_base = 16'd9 + {6'd0, node_id, 2'b00};
  assign slot_end  = slot_base + 16'd4;

  assign cmd_in_slot = (cmd_payload_pos >= slot_base) &&
                       (cmd_payload_pos < slot_end);
  assign cmd_lane  = cmd_payload_pos[1:0] - slot_base[1:0];
  // positions 1..8 map to time bytes 0..7; low 3 bits minus one wraps 8 to 7
  assign time_lane = cmd_payload_pos[2:0] - 3'd1;

  assign ret_lane = ret_payload_pos[1:0] - slot_base[1:0];
  assign ret_hit  = ret_payload_valid && meas_valid_q && node_ok &&
                    (ret_payload_pos >= slot_base) &&
                    (ret_payload_pos < slot_end);

  assign pkt_ok = !cmd_rx_error && (cmd_rx_length == EXP_LEN) && node_ok;

  assign target   = TIMER_WIDTH'(rx_time_q) + TIMER_WIDTH'(own_offset_q);
  assign diff     = target - local_start_q;
  assign diff_mag = diff[TIMER_WIDTH-1] ? (~diff + 1'b1) : diff;
  assign elapsed  = current_time - local_start_q;
  assign adj_need = (diff != '0) && !(DB_EN && (diff_mag <= DB_LIM));

  always_comb begin
    state_d        = state_q;
    local_start_d  = local_start_q;
    cmd_d          = cmd_q;
    rx_time_d      = rx_time_q;
    own_offset_d   = own_offset_q;
    cmd_seen_d     = cmd_seen_q;
    meas_valid_d   = meas_valid_q;
    rtt_d          = rtt_q;
    set_time_d     = set_time_q;
    set_valid_d    = 1'b0;
    adjust_sign_d  = adjust_sign_q;
    adjust_valid_d = adjust_valid_q;

    if (cmd_rx_start) begin
      local_start_d = current_time;
      cmd_d         = '0;
      rx_time_d     = '0;
      own_offset_d  = '0;
    end

    if (cmd_payload_valid) begin
      if (cmd_payload_pos == 16'd0) begin
        cmd_d = cmd_payload_data[1:0];
      end else if (cmd_payload_pos <= 16'd8) begin
        rx_time_d[{time_lane, 3'b000} +: 8] = cmd_payload_data;
      end else if (cmd_in_slot && node_ok) begin
        own_offset_d[{cmd_lane, 3'b000} +: 8] = cmd_payload_data;
      end
    end

    if (ret_rx_end || ret_rx_error) begin
      meas_valid_d = 1'b0;
    end

    // return start sees the previous command; a coincident command start
    // re-arms cmd_seen afterwards
    if (ret_rx_start) begin
      if (cmd_seen_q) begin
        rtt_d        = current_time[31:0] - local_start_q[31:0];
        meas_valid_d = 1'b1;
        cmd_seen_d   = 1'b0;
      end else begin
        meas_valid_d = 1'b0;
      end
    end

    if (cmd_rx_start) begin
      cmd_seen_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_rx_end && pkt_ok) begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (cmd_q[1]) begin
          state_d     = S_SET;
          set_valid_d = 1'b1;
          set_time_d  = target + elapsed;
        end else if (cmd_q[0] && adj_need) begin
          state_d        = S_ADJ;
          adjust_valid_d = 1'b1;
          adjust_sign_d  = diff[TIMER_WIDTH-1];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SET: begin
        state_d = S_IDLE;
      end
      S_ADJ: begin
        if (adjust_ready) begin
          state_d        = S_IDLE;
          adjust_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      local_start_q  <= '0;
      cmd_q          <= '0;
      rx_time_q      <= '0;
      own_offset_q   <= '0;
      cmd_seen_q     <= 1'b0;
      meas_valid_q   <= 1'b0;
      rtt_q          <= '0;
      set_time_q     <= '0;
      set_valid_q    <= 1'b0;
      adjust_sign_q  <= 1'b0;
      adjust_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      local_start_q  <= local_start_d;
      cmd_q          <= cmd_d;
      rx_time_q      <= rx_time_d;
      own_offset_q   <= own_offset_d;
      cmd_seen_q     <= cmd_seen_d;
      meas_valid_q   <= meas_valid_d;
      rtt_q          <= rtt_d;
      set_time_q     <= set_time_d;
      set_valid_q    <= set_valid_d;
      adjust_sign_q  <= adjust_sign_d;
      adjust_valid_q <= adjust_valid_d;
    end
  end

  assign set_time          = set_time_q;
  assign set_valid         = set_valid_q;
  assign adjust_sign       = adjust_sign_q;
  assign adjust_valid      = adjust_valid_q;
  assign ret_replace_valid = ret_hit;
  assign ret_replace_data  = ret_hit ? rtt_q[{ret_lane, 3'b000} +: 8] : 8'd0;

endmodule
